window_read_ctrl: RTL and testbench
===================================

Name: window_read_ctrl

Overview:
- Consumer-side controller for the spatial filter's line storage.
- Accepts a raster pixel stream and writes it round-robin into four internal line stores.
- Once three full lines are buffered, it reads those three lines in lockstep and emits a 3x3 pixel window (72 bits) every cycle to the convolution stage.
- The fourth store is filled concurrently. A one-cycle interrupt marks each completed line read, so the host can push the next line.

Parameters:
- LINE_W, 512, pixels per line; must be a power of two, at least 4.
- PIX_W, 8, bits per pixel.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; synchronous, active-high.
- i_pixel_data  in  PIX_W  incoming pixel, raster order.
- i_pixel_valid  in  1  pixel qualifier; one pixel accepted per asserted cycle, no backpressure.
- o_window  out  9*PIX_W  window data. Bits [71:48] are the oldest row, [47:24] the middle row, [23:0] the newest row. Each row is {col c, c+1, c+2} with col c in the MSBs.
- o_window_valid  out  1  o_window is valid this cycle.
- o_intr  out  1  one-cycle pulse when a line read completes.

Behaviour:
- Reset values:
  - o_window = 0, o_window_valid = 0, o_intr = 0.
  - Write column, write select, read column, read select and pixel count all = 0.
  - State = IDLE.
- Write path:
  - Each valid pixel goes to store[wr_sel] at address wr_col.
  - wr_col increments. When it wraps from LINE_W-1 to 0, wr_sel advances modulo 4.
- Pixel count (width log2(4*LINE_W)+1):
  - +1 on write only, -1 on read only, unchanged when a write and a read occur in the same cycle.
- State machine:
  - IDLE -> READ when pixel count >= 3*LINE_W.
  - READ: rd_en is asserted for exactly LINE_W consecutive cycles; rd_col runs 0..LINE_W-1.
  - On the last read cycle: rd_col -> 0, rd_sel advances modulo 4, o_intr pulses in the following cycle, state -> IDLE.
  - IDLE re-evaluates the count the cycle after returning. Back-to-back lines therefore have exactly one idle cycle between them.
- Row mapping:
  - Rows are store[rd_sel], store[rd_sel+1] and store[rd_sel+2] (all modulo 4), oldest to newest.
- Read latency and output timing:
  - o_window and o_window_valid are registered, one cycle after the rd_en cycle.
  - o_window holds its last value when valid is low.
- Taps: column indices c+1 and c+2 wrap modulo LINE_W (macro off).
- Overflow:
  - A write into the store currently being read is a protocol violation; data is not protected.
  - The host must wait for o_intr before sending the line that follows the fourth buffered line.
- Reset mid-operation:
  - All pointers and the count clear the next cycle, and any READ is aborted.
  - Store contents are not cleared, and stale data is never emitted as valid.
- Simultaneous write and read in the same store index set are legal, since write and read target different stores.

Optional Feature:
- Macro EDGE_REPLICATE_EN.
- Defined: taps beyond LINE_W-1 are clamped to LINE_W-1. At c = LINE_W-2 a row is {p[L-2], p[L-1], p[L-1]}; at c = LINE_W-1 it is {p[L-1], p[L-1], p[L-1]}.
- Undefined: modulo wrap, so at c = LINE_W-1 a row is {p[L-1], p[0], p[1]}.

Decomposition:
- Shared package holds:
  - LINE_W and PIX_W defaults.
  - State encoding typedef (IDLE, READ).
  - Constant NUM_STORES = 4.
  - Function for the 3*LINE_W fill threshold.
- Sub-module line_store:
  - One LINE_W x PIX_W memory with a write port and a read column input.
  - Returns three taps at c, c+1 and c+2, applying the wrap or clamp rule.
  - window_read_ctrl instantiates four of them.

Test Plan:
- LINE_W=8, stream 24 pixels valued 0..23 continuously:
  - o_window_valid rises 2 cycles after the 24th accept and stays high 8 cycles.
  - First window = {0,1,2, 8,9,10, 16,17,18}.
  - o_intr pulses once after the 8th valid window.
- LINE_W=8, macro off, last window of that line: oldest row = {7,0,1}, newest row = {23,16,17}. Macro on: oldest row = {7,7,7}.
- Feed 32 pixels continuously:
  - Second line read starts after the first o_intr plus one idle cycle.
  - First window = {8,9,10, 16,17,18, 24,25,26}.
  - Count during the overlap of write and read stays flat.
- Feed 23 pixels only: no o_window_valid and no o_intr for 100 cycles.
- Assert i_rst for 1 cycle midway through a READ:
  - o_window_valid = 0 from the next cycle, no o_intr.
  - A fresh 24 pixels reproduce the first-window result above.
- Rotation: stream 6 lines of 8:
  - Third window set uses stores 2,3,0.
  - Its first window = {16,17,18, 24,25,26, 32,33,34}.

Source files
------------

// File: rtl/window_read_ctrl_pkg.sv
// Shared constants and types for window_read_ctrl and its line stores.
package window_read_ctrl_pkg;

  localparam int unsigned LINE_W_DEFAULT = 512;
  localparam int unsigned PIX_W_DEFAULT  = 8;
  localparam int unsigned NUM_STORES     = 4;

  typedef enum logic {
    IDLE,
    READ
  } state_t;

  // Number of buffered pixels needed before a window set can be read.
  function automatic int unsigned fill_threshold(input int unsigned line_w);
    return 3 * line_w;
  endfunction

endpackage

// File: rtl/window_read_ctrl_line_store.sv
// line_store: one LINE_W x PIX_W line memory.
// Ports: write port (i_wr_en/i_wr_col/i_wr_data), read column i_rd_col,
// combinational taps o_tap0..2 at columns c, c+1, c+2.
// EDGE_REPLICATE_EN: clamp taps past the last column instead of wrapping.
module line_store
  import window_read_ctrl_pkg::*;
#(
  parameter int unsigned LINE_W = LINE_W_DEFAULT,
  parameter int unsigned PIX_W  = PIX_W_DEFAULT,
  localparam int unsigned AW    = $clog2(LINE_W)
) (
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_col,
  input  logic [PIX_W-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_col,
  output logic [PIX_W-1:0] o_tap0,
  output logic [PIX_W-1:0] o_tap1,
  output logic [PIX_W-1:0] o_tap2
);

  localparam logic [AW-1:0] LAST_COL = AW'(LINE_W - 1);

  logic [PIX_W-1:0] mem_q [LINE_W];
  logic [AW-1:0]    col1;
  logic [AW-1:0]    col2;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem_q[i_wr_col] <= i_wr_data;
    end
  end

  // LINE_W is a power of two, so plain AW-bit addition is the modulo wrap.
  always_comb begin
`ifdef EDGE_REPLICATE_EN
    col1 = (i_rd_col == LAST_COL) ? LAST_COL : i_rd_col + AW'(1);
    col2 = (i_rd_col >= LAST_COL - AW'(1)) ? LAST_COL : i_rd_col + AW'(2);
`else
    col1 = i_rd_col + AW'(1);
    col2 = i_rd_col + AW'(2);
`endif
  end

  assign o_tap0 = mem_q[i_rd_col];
  assign o_tap1 = mem_q[col1];
  assign o_tap2 = mem_q[col2];

endmodule

// File: rtl/window_read_ctrl.sv
// window_read_ctrl: writes a raster pixel stream round-robin into four line
// stores and, once three lines are buffered, emits one 3x3 window per cycle.
// Ports: i_clk, i_rst (sync, active-high), i_pixel_data/i_pixel_valid in;
// o_window (oldest row in MSBs), o_window_valid, o_intr (line read done) out.
// EDGE_REPLICATE_EN: clamp right-edge taps instead of wrapping.
module window_read_ctrl
  import window_read_ctrl_pkg::*;
#(
  parameter int unsigned LINE_W = LINE_W_DEFAULT,
  parameter int unsigned PIX_W  = PIX_W_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [PIX_W-1:0]   i_pixel_data,
  input  logic               i_pixel_valid,
  output logic [9*PIX_W-1:0] o_window,
  output logic               o_window_valid,
  output logic               o_intr
);

  localparam int unsigned AW = $clog2(LINE_W);
  localparam int unsigned CW = $clog2(4 * LINE_W) + 1;
  localparam int unsigned SW = $clog2(NUM_STORES);
  localparam logic [CW-1:0] FILL_THR = CW'(fill_threshold(LINE_W));
  localparam logic [AW-1:0] LAST_COL = AW'(LINE_W - 1);

  state_t             state_q, state_d;
  logic [AW-1:0]      wr_col_q, wr_col_d;
  logic [AW-1:0]      rd_col_q, rd_col_d;
  logic [SW-1:0]      wr_sel_q, wr_sel_d;
  logic [SW-1:0]      rd_sel_q, rd_sel_d;
  logic [CW-1:0]      count_q, count_d;
  logic [9*PIX_W-1:0] window_q, window_d;
  logic               window_valid_q, window_valid_d;
  logic               intr_q, intr_d;

  logic               rd_en;
  logic [SW-1:0]      sel_mid;
  logic [SW-1:0]      sel_new;
  logic [PIX_W-1:0]   tap0 [NUM_STORES];
  logic [PIX_W-1:0]   tap1 [NUM_STORES];
  logic [PIX_W-1:0]   tap2 [NUM_STORES];

  for (genvar g = 0; g < NUM_STORES; g++) begin : g_store
    line_store #(
      .LINE_W (LINE_W),
      .PIX_W  (PIX_W)
    ) u_store (
      .i_clk     (i_clk),
      .i_wr_en   (i_pixel_valid && (wr_sel_q == SW'(g))),
      .i_wr_col  (wr_col_q),
      .i_wr_data (i_pixel_data),
      .i_rd_col  (rd_col_q),
      .o_tap0    (tap0[g]),
      .o_tap1    (tap1[g]),
      .o_tap2    (tap2[g])
    );
  end

  always_comb begin
    rd_en   = (state_q == READ);
    sel_mid = rd_sel_q + SW'(1);
    sel_new = rd_sel_q + SW'(2);

    wr_col_d = wr_col_q;
    wr_sel_d = wr_sel_q;
    if (i_pixel_valid) begin
      wr_col_d = wr_col_q + AW'(1);
      if (wr_col_q == LAST_COL) begin
        wr_sel_d = wr_sel_q + SW'(1);
      end
    end

    count_d = count_q;
    case ({i_pixel_valid, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    state_d  = state_q;
    rd_col_d = rd_col_q;
    rd_sel_d = rd_sel_q;
    intr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q >= FILL_THR) begin
          state_d = READ;
        end
      end
      READ: begin
        rd_col_d = rd_col_q + AW'(1);
        if (rd_col_q == LAST_COL) begin
          rd_col_d = '0;
          rd_sel_d = rd_sel_q + SW'(1);
          intr_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    window_valid_d = rd_en;
    window_d       = window_q;
    if (rd_en) begin
      window_d = {tap0[rd_sel_q], tap1[rd_sel_q], tap2[rd_sel_q],
                  tap0[sel_mid],  tap1[sel_mid],  tap2[sel_mid],
                  tap0[sel_new],  tap1[sel_new],  tap2[sel_new]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= IDLE;
      wr_col_q       <= '0;
      wr_sel_q       <= '0;
      rd_col_q       <= '0;
      rd_sel_q       <= '0;
      count_q        <= '0;
      window_q       <= '0;
      window_valid_q <= 1'b0;
      intr_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_col_q       <= wr_col_d;
      wr_sel_q       <= wr_sel_d;
      rd_col_q       <= rd_col_d;
      rd_sel_q       <= rd_sel_d;
      count_q        <= count_d;
      window_q       <= window_d;
      window_valid_q <= window_valid_d;
      intr_q         <= intr_d;
    end
  end

  assign o_window       = window_q;
  assign o_window_valid = window_valid_q;
  assign o_intr         = intr_q;

endmodule

// File: tb/tb_window_read_ctrl.sv
module tb_window_read_ctrl;

  localparam int L  = 8;
  localparam int PW = 8;

`ifdef EDGE_REPLICATE_EN
  localparam logic [71:0] LAST_EXP = 72'h070707_0F0F0F_171717;
`else
  localparam logic [71:0] LAST_EXP = 72'h070001_0F0809_171011;
`endif
  localparam logic [71:0] FIRST_EXP  = 72'h000102_08090A_101112;
  localparam logic [71:0] SECOND_EXP = 72'h08090A_101112_18191A;
  localparam logic [71:0] THIRD_EXP  = 72'h101112_18191A_202122;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [PW-1:0] i_pixel_data;
  logic          i_pixel_valid;
  logic [71:0]   o_window;
  logic          o_window_valid;
  logic          o_intr;

  always #5 i_clk = ~i_clk;

  window_read_ctrl #(
    .LINE_W (L),
    .PIX_W  (PW)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_pixel_data   (i_pixel_data),
    .i_pixel_valid  (i_pixel_valid),
    .o_window       (o_window),
    .o_window_valid (o_window_valid),
    .o_intr         (o_intr)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  logic [71:0] exp_q [$];
  logic [71:0] seen  [$];
  int          stream [$];
  int          win_cnt    = 0;
  int          intr_total = 0;
  int          flush_gen  = 0;

  int          k, run, gap, nv, ni;
  logic [71:0] last_w;

  task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: a window set n covers lines n, n+1, n+2 of the stream since reset.
  function automatic int tap_col(input int idx);
`ifdef EDGE_REPLICATE_EN
    return (idx > L - 1) ? L - 1 : idx;
`else
    return idx % L;
`endif
  endfunction

  function automatic logic [71:0] model_window(input int n, input int c);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int t = 0; t < 3; t++)
        w = {w[63:0], 8'(stream[(n + r) * L + tap_col(c + t)])};
    return w;
  endfunction

  task automatic send_pixel(input logic [7:0] d);
    int nl;
    i_pixel_valid = 1'b1;
    i_pixel_data  = d;
    stream.push_back(int'(d));
    if (stream.size() % L == 0) begin
      nl = stream.size() / L;
      if (nl >= 3)
        for (int c = 0; c < L; c++) exp_q.push_back(model_window(nl - 3, c));
    end
    @(posedge i_clk); #1;
    i_pixel_valid = 1'b0;
  endtask

  task automatic wait_intr(input int need);
    int budget;
    budget = 0;
    while (intr_total < need && budget < 3000) begin
      @(posedge i_clk); #1;
      budget++;
    end
    if (intr_total < need) begin
      vectors++;
      miscompares++;
      $display("FAIL intr_timeout: got %0d interrupts expected %0d", intr_total, need);
    end
  endtask

  // Line k reuses the store of line k-4, which is free once set k-4 finishes.
  task automatic send_line(input bit rnd, input int max_gap);
    int ln;
    ln = stream.size() / L;
    if (ln >= 4) wait_intr(ln - 3);
    for (int c = 0; c < L; c++) begin
      if (max_gap > 0)
        repeat ($urandom_range(max_gap, 0)) begin @(posedge i_clk); #1; end
      send_pixel(rnd ? 8'($urandom) : 8'(ln * L + c));
    end
  endtask

  task automatic do_reset(input int cycles);
    i_rst = 1'b1;
    i_pixel_valid = 1'b0;
    repeat (cycles) begin @(posedge i_clk); #1; end
    i_rst = 1'b0;
    stream.delete();
    flush_gen++;
  endtask

  task automatic wait_valid(input int limit);
    k = 0;
    do begin
      @(posedge i_clk); #1;
      k++;
    end while (!o_window_valid && k < limit);
  endtask

  // Monitor / scoreboard
  initial begin
    int seen_gen;
    logic [71:0] e;
    seen_gen = 0;
    forever begin
      @(negedge i_clk);
      if (seen_gen != flush_gen) begin
        seen_gen   = flush_gen;
        win_cnt    = 0;
        intr_total = 0;
        seen.delete();
        exp_q.delete();
      end
      if (!i_rst) begin
        if (o_window_valid) begin
          seen.push_back(o_window);
          if (exp_q.size() == 0) begin
            check("unexpected_window_valid", 72'(o_window_valid), 72'd0);
          end else begin
            e = exp_q.pop_front();
            check("window", o_window, e);
            win_cnt++;
          end
        end
        if (o_intr || win_cnt == L) begin
          check("intr_at_line_end", {70'd0, o_intr, (win_cnt == L)}, 72'd3);
          if (o_intr) intr_total++;
          win_cnt = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_rst = 1'b1;
    i_pixel_valid = 1'b0;
    i_pixel_data = '0;
    do_reset(3);
    @(negedge i_clk);
    check("reset_window", o_window, 72'd0);
    check("reset_valid", 72'(o_window_valid), 72'd0);
    check("reset_intr", 72'(o_intr), 72'd0);
    @(posedge i_clk); #1;

    // Three lines 0..23: latency, window contents, run length
    for (int i = 0; i < 24; i++) send_pixel(8'(i));
    wait_valid(20);
    check("first_valid_latency", 72'(k), 72'd2);
    check("first_window", o_window, FIRST_EXP);
    run = 1;
    last_w = o_window;
    while (run < 40) begin
      @(posedge i_clk); #1;
      if (!o_window_valid) break;
      run++;
      last_w = o_window;
    end
    check("valid_run_len", 72'(run), 72'd8);
    check("last_window", last_w, LAST_EXP);

    // Four lines: back-to-back sets with one idle cycle
    do_reset(1);
    for (int i = 0; i < 4; i++) send_line(1'b0, 0);
    k = 0;
    while (o_window_valid && k < 40) begin @(posedge i_clk); #1; k++; end
    gap = 0;
    while (!o_window_valid && gap < 40) begin @(posedge i_clk); #1; gap++; end
    check("idle_gap", 72'(gap), 72'd1);
    check("second_set_first_window", o_window, SECOND_EXP);
    run = 1;
    while (run < 40) begin
      @(posedge i_clk); #1;
      if (!o_window_valid) break;
      run++;
    end
    check("second_run_len", 72'(run), 72'd8);

    // 23 pixels: nothing must come out
    do_reset(1);
    for (int i = 0; i < 23; i++) send_pixel(8'(i));
    nv = 0; ni = 0;
    repeat (100) begin
      @(posedge i_clk); #1;
      if (o_window_valid) nv++;
      if (o_intr) ni++;
    end
    check("short_fill_valids", 72'(nv), 72'd0);
    check("short_fill_intrs", 72'(ni), 72'd0);

    // Reset in the middle of a read
    do_reset(1);
    for (int i = 0; i < 24; i++) send_pixel(8'(i));
    wait_valid(20);
    repeat (2) begin @(posedge i_clk); #1; end
    do_reset(1);
    check("valid_after_reset", 72'(o_window_valid), 72'd0);
    nv = 0; ni = 0;
    repeat (20) begin
      @(posedge i_clk); #1;
      if (o_window_valid) nv++;
      if (o_intr) ni++;
    end
    check("post_reset_valids", 72'(nv), 72'd0);
    check("post_reset_intrs", 72'(ni), 72'd0);
    for (int i = 0; i < 24; i++) send_pixel(8'(i));
    wait_valid(20);
    check("refill_first_window", o_window, FIRST_EXP);

    // Rotation over six lines
    do_reset(1);
    for (int i = 0; i < 6; i++) send_line(1'b0, 0);
    k = 0;
    while (seen.size() <= 2 * L && k < 200) begin @(posedge i_clk); #1; k++; end
    check("third_set_first_window", (seen.size() > 2 * L) ? seen[2 * L] : 72'd0, THIRD_EXP);

    // Random data with random gaps
    do_reset(1);
    for (int i = 0; i < 12; i++) send_line(1'b1, 3);
    k = 0;
    while (exp_q.size() != 0 && k < 2000) begin @(posedge i_clk); #1; k++; end
    repeat (4) begin @(posedge i_clk); #1; end
    check("scoreboard_drained", 72'(exp_q.size()), 72'd0);
    check("random_intr_total", 72'(intr_total), 72'd10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
